// File: rtl/regfile_multiport.sv
// Multiported register file for the decode stage: two combinational read
// ports, two clocked write ports, and a per-entry pending scoreboard.
// After reset a sweep clears the storage one entry per cycle, so the array
// can map onto a RAM with no reset. `ready` rises once the sweep is done.
//
// Handshake: there is no flow control. Writes and reserves act only in RUN
// and are ignored during the sweep. Callers must wait for `ready` before
// relying on any read data or busy flag.
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  wrEnA,
  input  logic [ADDR_WIDTH-1:0] wrRegA,
  input  logic [DATA_WIDTH-1:0] wrDataA,
  input  logic                  wrEnB,
  input  logic [ADDR_WIDTH-1:0] wrRegB,
  input  logic [DATA_WIDTH-1:0] wrDataB,
  input  logic                  reserveEn,
  input  logic [ADDR_WIDTH-1:0] reserveReg,
  output logic                  ready,
  output logic                  dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    ready_q, ready_d;
  logic [DEPTH-1:0]        pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    run;
  logic                    we_a, we_b, rsv_en;
  logic [ADDR_WIDTH-1:0]   rd_idx  [2];
  logic [DATA_WIDTH-1:0]   rd_data [2];
  logic                    rd_busy [2];

  assign run = (state_q == RUN);

  // An index-0 access with ZERO_REG set is dropped at the source.
  assign we_a   = run && wrEnA && !(ZERO_REG && (wrRegA == '0));
  assign we_b   = run && wrEnB && !(ZERO_REG && (wrRegB == '0));
  assign rsv_en = run && reserveEn && !(ZERO_REG && (reserveReg == '0));

  // Control state: sweep FSM, registered ready, and pending bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic: advance the sweep, then update the scoreboard in RUN.
  // A write clears first and a reserve sets afterwards, so the new producer wins.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    pend_d  = pend_q;
    case (state_q)
      SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        if (wrEnA)  pend_d[wrRegA]     = 1'b0;
        if (wrEnB)  pend_d[wrRegB]     = 1'b0;
        if (rsv_en) pend_d[reserveReg] = 1'b1;
      end
      default: state_d = SWEEP;
    endcase
  end

  // Storage has no reset. The sweep zeroes it, and B is written last so it
  // overrides A when both ports target the same entry.
  always_ff @(posedge clock) begin
    if (!run) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (we_a) mem_q[wrRegA] <= wrDataA;
      if (we_b) mem_q[wrRegB] <= wrDataB;
    end
  end

  assign rd_idx[0] = readRegister1;
  assign rd_idx[1] = readRegister2;

  // Combinational reads, with an optional same-cycle bypass of write data.
  // The B-port bypass is applied last so that B takes priority over A.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (run && !(ZERO_REG && (rd_idx[p] == '0))) begin
        rd_data[p] = mem_q[rd_idx[p]];
        rd_busy[p] = pend_q[rd_idx[p]];
        if (BYPASS) begin
          if (wrEnA && (wrRegA == rd_idx[p])) rd_data[p] = wrDataA;
          if (wrEnB && (wrRegB == rd_idx[p])) rd_data[p] = wrDataB;
        end
      end
    end
  end

  assign readData1   = rd_data[0];
  assign readData2   = rd_data[1];
  assign busy1       = rd_busy[0];
  assign busy2       = rd_busy[1];
  assign ready       = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport. Two instances share one stimulus stream:
//   u0: default configuration (32x32, ZERO_REG=1, BYPASS=1).
//   u1: 16-bit data, 8 entries, ZERO_REG=0, BYPASS=0.
// u1 sees the low bits of each index and data input.
module tb_regfile_multiport;

  logic        clock, reset_n;
  logic [4:0]  rr1, rr2, wra, wrb, rsv;
  logic [31:0] wda, wdb;
  logic        wea, web, rse;

  logic [31:0] d1_0, d2_0;
  logic        b1_0, b2_0, rdy_0, st_0;
  logic [15:0] d1_1, d2_1;
  logic        b1_1, b2_1, rdy_1, st_1;

  int vectors;
  int miscompares;

  // Reference model state, indexed by instance.
  logic [31:0] m_mem  [2][32];
  logic        m_pend [2][32];
  int          m_cnt  [2];

  regfile_multiport u0 (
    .clock(clock), .reset_n(reset_n),
    .readRegister1(rr1), .readRegister2(rr2),
    .readData1(d1_0), .readData2(d2_0), .busy1(b1_0), .busy2(b2_0),
    .wrEnA(wea), .wrRegA(wra), .wrDataA(wda),
    .wrEnB(web), .wrRegB(wrb), .wrDataB(wdb),
    .reserveEn(rse), .reserveReg(rsv),
    .ready(rdy_0), .dbg_state_o(st_0)
  );

  regfile_multiport #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (
    .clock(clock), .reset_n(reset_n),
    .readRegister1(rr1[2:0]), .readRegister2(rr2[2:0]),
    .readData1(d1_1), .readData2(d2_1), .busy1(b1_1), .busy2(b2_1),
    .wrEnA(wea), .wrRegA(wra[2:0]), .wrDataA(wda[15:0]),
    .wrEnB(web), .wrRegB(wrb[2:0]), .wrDataB(wdb[15:0]),
    .reserveEn(rse), .reserveReg(rsv[2:0]),
    .ready(rdy_1), .dbg_state_o(st_1)
  );

  // Clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int depth_of(int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic logic [31:0] dmask(int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic logic [4:0] amask(int k);
    return (k == 0) ? 5'd31 : 5'd7;
  endfunction

  function automatic bit has_zero(int k);
    return (k == 0);
  endfunction

  function automatic bit has_bypass(int k);
    return (k == 0);
  endfunction

  function automatic bit m_ready(int k);
    return m_cnt[k] >= depth_of(k);
  endfunction

  // Expected result of a read, computed from the current model state and the current inputs.
  task automatic exp_read(input int k, input logic [4:0] r,
                          output logic [31:0] d, output logic b);
    logic [4:0] idx;
    idx = r & amask(k);
    d = '0;
    b = 1'b0;
    if (m_ready(k) && !(has_zero(k) && idx == 5'd0)) begin
      d = m_mem[k][idx];
      b = m_pend[k][idx];
      if (has_bypass(k)) begin
        if (wea && ((wra & amask(k)) == idx)) d = wda;
        if (web && ((wrb & amask(k)) == idx)) d = wdb;
      end
      d = d & dmask(k);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
    end
  endtask

  // Apply one rising edge to the model.
  task automatic model_edge();
    logic [4:0] a, b, r;
    if (!reset_n) return;
    for (int k = 0; k < 2; k++) begin
      if (!m_ready(k)) begin
        m_cnt[k]++;
        if (m_ready(k))
          for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
      end else begin
        a = wra & amask(k);
        b = wrb & amask(k);
        r = rsv & amask(k);
        if (wea && !(has_zero(k) && a == 5'd0)) m_mem[k][a] = wda & dmask(k);
        if (web && !(has_zero(k) && b == 5'd0)) m_mem[k][b] = wdb & dmask(k);
        if (wea) m_pend[k][a] = 1'b0;
        if (web) m_pend[k][b] = 1'b0;
        if (rse && !(has_zero(k) && r == 5'd0)) m_pend[k][r] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s u%0d t=%0t observed=%h expected=%h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e1, e2;
    logic        eb1, eb2;
    for (int k = 0; k < 2; k++) begin
      exp_read(k, rr1, e1, eb1);
      exp_read(k, rr2, e2, eb2);
      chk("ready", k, {31'd0, (k == 0) ? rdy_0 : rdy_1}, {31'd0, m_ready(k)});
      chk("state", k, {31'd0, (k == 0) ? st_0 : st_1}, {31'd0, m_ready(k)});
      chk("rdata1", k, (k == 0) ? d1_0 : {16'd0, d1_1}, e1);
      chk("rdata2", k, (k == 0) ? d2_0 : {16'd0, d2_1}, e2);
      chk("busy1", k, {31'd0, (k == 0) ? b1_0 : b1_1}, {31'd0, eb1});
      chk("busy2", k, {31'd0, (k == 0) ? b2_0 : b2_1}, {31'd0, eb2});
    end
  endtask

  // One cycle: check the combinational outputs mid-cycle, then advance the edge.
  task automatic step();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wea = 1'b0; web = 1'b0; rse = 1'b0;
    wra = '0; wrb = '0; rsv = '0; wda = '0; wdb = '0;
  endtask

  // Drop reset between edges, check the immediate effect, then release after some edges.
  task automatic apply_reset(input int edges);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (edges) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b1;
    rr1 = '0; rr2 = '0;
    idle();
    model_reset();
    @(posedge clock); #1;

    // Reset and sweep. A write issued during the sweep must be ignored.
    apply_reset(3);
    wea = 1'b1; wra = 5'd5; wda = 32'h0000_DEAD; rr1 = 5'd5;
    step();
    idle();
    repeat (34) step();
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(31 - i);
      step();
    end

    // Basic write/read, and writes to the zero register.
    wea = 1'b1; wra = 5'd7; wda = 32'hA5A5_A5A5; rr1 = 5'd7;
    step();
    idle(); step();
    wea = 1'b1; wra = 5'd0; wda = 32'hFFFF_1234; rr1 = 5'd0; rr2 = 5'd7;
    step();
    idle(); step();

    // Dual write to one register: B wins, and the read shows bypass or old data.
    wea = 1'b1; wra = 5'd3; wda = 32'h11;
    web = 1'b1; wrb = 5'd3; wdb = 32'h22; rr1 = 5'd3;
    step();
    idle(); step();

    // Scoreboard behaviour.
    rse = 1'b1; rsv = 5'd9; rr1 = 5'd9; rr2 = 5'd1;
    step();
    idle(); step();
    web = 1'b1; wrb = 5'd9; wdb = 32'h99;
    step();
    idle(); step();
    rse = 1'b1; rsv = 5'd9; wea = 1'b1; wra = 5'd9; wda = 32'h77;
    step();
    idle(); step();
    rse = 1'b1; rsv = 5'd0; rr1 = 5'd0;
    step();
    idle(); step();

    // Reset in the middle of RUN, with live data and a pending bit.
    wea = 1'b1; wra = 5'd4; wda = 32'h4444_4444;
    web = 1'b1; wrb = 5'd9; wdb = 32'h9999_9999;
    step();
    idle(); rse = 1'b1; rsv = 5'd9; rr1 = 5'd9; rr2 = 5'd4;
    step();
    idle(); step();
    #2;
    apply_reset(1);
    repeat (33) step();
    rr1 = 5'd4; rr2 = 5'd9;
    step();

    // Random traffic with frequent index collisions.
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 3) == 0);
      wea = 1'($urandom_range(0, 1));
      web = 1'($urandom_range(0, 1));
      rse = ($urandom_range(0, 2) == 0);
      wra = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wrb = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rsv = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rr1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rr2 = 5'($urandom);
      wda = $urandom;
      wdb = $urandom;
      step();
      if (n == 200) begin
        idle();
        #2;
        apply_reset(2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
